input_router_xy_vc: RTL and testbench
=====================================

Name: input_router_xy_vc

Overview:
Parametrised successor to the single-channel input router. It sits at each NoC router input port, directly after the input buffer. It computes an XY dimension-order route for head flits and records the route in a per-virtual-channel table. Body and tail flits are steered using the stored route. The result is a registered one-hot output-port request with valid/ready backpressure toward the switch allocator.

Parameters:
NUM_VC, 4, number of virtual channels (≥2, power of 2); VC_W = clog2(NUM_VC)
X_W, 2, destination X coordinate width
Y_W, 2, destination Y coordinate width
ROUTER_X, 0, this router's X coordinate
ROUTER_Y, 0, this router's Y coordinate
FLIT_WIDTH, 37, total flit width (≥ 2+VC_W+X_W+Y_W)

Ports:
clk  in  1  clock
arst  in  1  reset, synchronous, active-high (name kept per codebase)
flit_valid_i  in  1  input flit valid
flit_ready_o  out  1  router accepts flit this cycle
flit_i  in  FLIT_WIDTH  flit; [1:0] type, [2+:VC_W] vc, [2+VC_W+:X_W] dest X, [2+VC_W+X_W+:Y_W] dest Y
route_valid_o  out  1  routed flit valid
route_ready_i  in  1  allocator accepts routed flit
router_port_o  out  5  one-hot: [0]N [1]S [2]W [3]E [4]Local; all-zero = no route
route_vc_o  out  VC_W  VC of routed flit
route_flit_o  out  FLIT_WIDTH  flit passed through unchanged
err_o  out  2  sticky: [0] orphan body/tail, [1] head on already-open VC
stats_o  out  80  per-port head counters, 5×16 (see Optional Feature)

Behaviour:
- Flit types: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head+tail).
- Accept when flit_valid_i && flit_ready_o. flit_ready_o = !route_valid_o || route_ready_i. This is a single output register, full throughput, and there is no combinational path from flit_valid_i to flit_ready_o.
- Latency: exactly 1 cycle from accept to route_valid_o. The output register holds stable while route_valid_o && !route_ready_i.
- XY route for head/single flits:
  - dest X > ROUTER_X → E; dest X < ROUTER_X → W.
  - Otherwise, dest Y > ROUTER_Y → S; dest Y < ROUTER_Y → N.
  - Otherwise → Local.
- Route table: NUM_VC entries, each {open, port[4:0]}.
  - Head accept: write entry[vc] = {1, xy_port}. If the entry was already open, set err_o[1] and overwrite anyway.
  - Single accept: use xy_port and leave the entry closed. If the entry was already open, set err_o[1] and close it.
  - Body accept: if entry[vc].open, use its port; otherwise router_port_o = 5'b0 and set err_o[0]. The flit is still forwarded.
  - Tail accept: same as body, and additionally close entry[vc] (open = 0) on the accept cycle.
- Table updates happen only on accept. A head and a tail on different VCs in successive cycles are independent.
- A body flit accepted in the cycle after its head sees the updated entry; the write completes on the head's accept edge.
- Reset (any cycle, including mid-packet):
  - route_valid_o = 0, router_port_o = 0, route_vc_o = 0, route_flit_o = 0.
  - All entries closed, port = 0.
  - err_o = 0; stats cleared.
  - flit_ready_o = 1 in the first cycle after reset deasserts.
  - An in-flight output is dropped.
- err_o bits are sticky until reset.

Optional Feature:
ROUTE_STATS_EN
- Defined: five 16-bit counters, one per output port. Each increments on each accepted head or single flit whose XY port selects it, saturating at 16'hFFFF. Packed into stats_o: port p occupies [16p+:16]. Cleared by reset.
- Undefined: no counters are built; stats_o is tied to 0.

Test Plan:
1. ROUTER_X=1, ROUTER_Y=1. Head on VC2 with dest (3,1), then body and tail on VC2 → router_port_o 5'b01000 for all three, each 1 cycle after accept. Entry 2 is closed after the tail.
2. Interleave VC0 head dest (0,1) (→W 00100) and VC1 head dest (1,3) (→S 00010), then VC0 body, VC1 body, VC0 tail, VC1 tail → ports follow the VCs correctly; err_o = 0.
3. Single flit dest (1,1) → router_port_o 5'b10000. A following body flit on the same VC → router_port_o 0 and err_o = 2'b01.
4. Head on VC3, then a second head on VC3 with a new dest → err_o[1] = 1 and the new port is used for subsequent bodies.
5. Hold route_ready_i = 0 for 3 cycles with flit_valid_i = 1 → flit_ready_o = 0 and outputs stable. Release → one flit transfers per cycle with no loss or duplication.
6. Assert arst after a head on VC1 → all outputs 0. A body on VC1 afterwards → port 0 and err_o[0] = 1. With ROUTE_STATS_EN defined, 3 heads to E → stats_o[63:48] = 3.

Source files
------------

// File: rtl/input_router_xy_vc.sv
// XY dimension-order input router with a per-VC route table; one registered output stage with valid/ready handshake.
// Optional ROUTE_STATS_EN builds per-port head counters on stats_o; without it stats_o is tied to zero.
module input_router_xy_vc #(
  parameter  int NUM_VC     = 4,
  parameter  int X_W        = 2,
  parameter  int Y_W        = 2,
  parameter  int ROUTER_X   = 0,
  parameter  int ROUTER_Y   = 0,
  parameter  int FLIT_WIDTH = 37,
  localparam int VC_W       = $clog2(NUM_VC)
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  flit_valid_i,
  output logic                  flit_ready_o,
  input  logic [FLIT_WIDTH-1:0] flit_i,
  output logic                  route_valid_o,
  input  logic                  route_ready_i,
  output logic [4:0]            router_port_o,
  output logic [VC_W-1:0]       route_vc_o,
  output logic [FLIT_WIDTH-1:0] route_flit_o,
  output logic [1:0]            err_o,
  output logic [79:0]           stats_o
);

  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  localparam logic [4:0] P_N = 5'b00001;
  localparam logic [4:0] P_S = 5'b00010;
  localparam logic [4:0] P_W = 5'b00100;
  localparam logic [4:0] P_E = 5'b01000;
  localparam logic [4:0] P_L = 5'b10000;

  localparam logic [X_W-1:0] RX = X_W'(ROUTER_X);
  localparam logic [Y_W-1:0] RY = Y_W'(ROUTER_Y);

  logic [1:0]      ftype;
  logic [VC_W-1:0] fvc;
  logic [X_W-1:0]  dx;
  logic [Y_W-1:0]  dy;
  logic            is_head;
  logic            accept;
  logic [4:0]      xy_port;
  logic [4:0]      sel_port;

  logic [NUM_VC-1:0] tbl_open;
  logic [4:0]        tbl_port [NUM_VC];

  assign ftype   = flit_i[1:0];
  assign fvc     = flit_i[2 +: VC_W];
  assign dx      = flit_i[2+VC_W +: X_W];
  assign dy      = flit_i[2+VC_W+X_W +: Y_W];
  assign is_head = (ftype == T_HEAD) || (ftype == T_SINGLE);

  // Ready depends only on the output register, never on flit_valid_i.
  assign flit_ready_o = !route_valid_o || route_ready_i;
  assign accept       = flit_valid_i && flit_ready_o;

  always_comb begin
    if (dx > RX)      xy_port = P_E;
    else if (dx < RX) xy_port = P_W;
    else if (dy > RY) xy_port = P_S;
    else if (dy < RY) xy_port = P_N;
    else              xy_port = P_L;
  end

  always_comb begin
    sel_port = '0;
    if (is_head)             sel_port = xy_port;
    else if (tbl_open[fvc])  sel_port = tbl_port[fvc];
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      route_valid_o <= 1'b0;
      router_port_o <= '0;
      route_vc_o    <= '0;
      route_flit_o  <= '0;
      err_o         <= '0;
      tbl_open      <= '0;
      for (int i = 0; i < NUM_VC; i++) tbl_port[i] <= '0;
    end else begin
      if (accept) begin
        route_valid_o <= 1'b1;
        router_port_o <= sel_port;
        route_vc_o    <= fvc;
        route_flit_o  <= flit_i;
        case (ftype)
          T_HEAD: begin
            if (tbl_open[fvc]) err_o[1] <= 1'b1;
            tbl_open[fvc] <= 1'b1;
            tbl_port[fvc] <= xy_port;
          end
          T_SINGLE: begin
            if (tbl_open[fvc]) err_o[1] <= 1'b1;
            tbl_open[fvc] <= 1'b0;
          end
          T_TAIL: begin
            if (!tbl_open[fvc]) err_o[0] <= 1'b1;
            tbl_open[fvc] <= 1'b0;
          end
          default: begin
            if (!tbl_open[fvc]) err_o[0] <= 1'b1;
          end
        endcase
      end else if (route_ready_i) begin
        route_valid_o <= 1'b0;
      end
    end
  end

`ifdef ROUTE_STATS_EN
  logic [15:0] cnt [5];

  // Saturating so a long-running port never wraps back to a small count.
  always_ff @(posedge clk) begin
    if (arst) begin
      for (int p = 0; p < 5; p++) cnt[p] <= '0;
    end else if (accept && is_head) begin
      for (int p = 0; p < 5; p++)
        if (xy_port[p] && cnt[p] != 16'hFFFF) cnt[p] <= cnt[p] + 16'd1;
    end
  end

  assign stats_o = {cnt[4], cnt[3], cnt[2], cnt[1], cnt[0]};
`else
  assign stats_o = '0;
`endif

endmodule

// File: tb/tb_input_router_xy_vc.sv
// Directed + randomized bench for input_router_xy_vc at router (1,1), checked against a queue-based reference model.
module tb_input_router_xy_vc;
  localparam int FW = 37;

  logic          clk = 1'b0;
  logic          arst;
  logic          flit_valid_i;
  logic          flit_ready_o;
  logic [FW-1:0] flit_i;
  logic          route_valid_o;
  logic          route_ready_i;
  logic [4:0]    router_port_o;
  logic [1:0]    route_vc_o;
  logic [FW-1:0] route_flit_o;
  logic [1:0]    err_o;
  logic [79:0]   stats_o;

  input_router_xy_vc #(
    .NUM_VC(4), .X_W(2), .Y_W(2), .ROUTER_X(1), .ROUTER_Y(1), .FLIT_WIDTH(FW)
  ) dut (
    .clk(clk), .arst(arst),
    .flit_valid_i(flit_valid_i), .flit_ready_o(flit_ready_o), .flit_i(flit_i),
    .route_valid_o(route_valid_o), .route_ready_i(route_ready_i),
    .router_port_o(router_port_o), .route_vc_o(route_vc_o), .route_flit_o(route_flit_o),
    .err_o(err_o), .stats_o(stats_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    port;
    logic [1:0]    vc;
    logic [FW-1:0] flit;
  } exp_t;

  exp_t       q[$];
  bit         m_open [4];
  logic [4:0] m_port [4];
  logic [1:0] m_err;
  int         m_stats [5];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] xy(input int x, input int y);
    if (x > 1) return 5'b01000;
    if (x < 1) return 5'b00100;
    if (y > 1) return 5'b00010;
    if (y < 1) return 5'b00001;
    return 5'b10000;
  endfunction

  function automatic logic [FW-1:0] mk(input int typ, input int vc, input int x, input int y);
    logic [28:0] pay;
    pay = 29'($urandom);
    return {pay, 2'(y), 2'(x), 2'(vc), 2'(typ)};
  endfunction

  task automatic model_clear();
    q.delete();
    m_err = 2'b00;
    for (int i = 0; i < 4; i++) begin m_open[i] = 0; m_port[i] = '0; end
    for (int p = 0; p < 5; p++) m_stats[p] = 0;
  endtask

  task automatic model_accept(input logic [FW-1:0] f);
    exp_t e;
    int typ, vc;
    logic [4:0] hp;
    typ = int'(f[1:0]);
    vc  = int'(f[3:2]);
    hp  = xy(int'(f[5:4]), int'(f[7:6]));
    e.vc = f[3:2];
    e.flit = f;
    if (typ == 1 || typ == 3) begin
      if (m_open[vc]) m_err[1] = 1'b1;
      m_open[vc] = (typ == 1);
      m_port[vc] = (typ == 1) ? hp : m_port[vc];
      e.port = hp;
      for (int p = 0; p < 5; p++) if (hp[p] && m_stats[p] < 65535) m_stats[p]++;
    end else begin
      if (m_open[vc]) e.port = m_port[vc];
      else begin e.port = '0; m_err[0] = 1'b1; end
      if (typ == 2) m_open[vc] = 0;
    end
    q.push_back(e);
  endtask

  function automatic logic [79:0] exp_stats();
    logic [79:0] s;
    s = '0;
`ifdef ROUTE_STATS_EN
    for (int p = 0; p < 5; p++) s[16*p +: 16] = 16'(m_stats[p]);
`endif
    return s;
  endfunction

  // One clock cycle: drive inputs after negedge, check outputs, advance the model, then check sticky state.
  task automatic step(input logic v, input logic [FW-1:0] f, input logic rdy);
    bit can_take, acc, xfer;
    flit_valid_i = v;
    flit_i = f;
    route_ready_i = rdy;
    #1;
    can_take = (q.size() == 0) || rdy;
    chk("flit_ready", 80'(flit_ready_o), 80'(can_take));
    chk("route_valid", 80'(route_valid_o), 80'(q.size() != 0));
    if (q.size() != 0) begin
      chk("port", 80'(router_port_o), 80'(q[0].port));
      chk("vc", 80'(route_vc_o), 80'(q[0].vc));
      chk("flit", 80'(route_flit_o), 80'(q[0].flit));
    end
    acc  = v && can_take;
    xfer = (q.size() != 0) && rdy;
    if (xfer) void'(q.pop_front());
    if (acc) model_accept(f);
    @(posedge clk);
    @(negedge clk);
    chk("err", 80'(err_o), 80'(m_err));
    chk("stats", stats_o, exp_stats());
  endtask

  task automatic do_reset();
    flit_valid_i = 1'b0;
    route_ready_i = 1'b0;
    arst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    model_clear();
    #1;
    chk("rst_valid", 80'(route_valid_o), 80'(0));
    chk("rst_port", 80'(router_port_o), 80'(0));
    chk("rst_vc", 80'(route_vc_o), 80'(0));
    chk("rst_flit", 80'(route_flit_o), 80'(0));
    chk("rst_err", 80'(err_o), 80'(0));
    chk("rst_stats", stats_o, 80'(0));
    chk("rst_ready", 80'(flit_ready_o), 80'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    arst = 1'b1;
    flit_valid_i = 1'b0;
    flit_i = '0;
    route_ready_i = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Packet to E on VC2; a body after the tail finds the entry closed.
    step(1'b1, mk(1, 2, 3, 1), 1'b1);
    step(1'b1, mk(0, 2, 0, 0), 1'b1);
    step(1'b1, mk(2, 2, 0, 0), 1'b1);
    step(1'b1, mk(0, 2, 0, 0), 1'b1);
    drain();
    chk("t1_err_closed", 80'(err_o), 80'(2'b01));
    do_reset();

    // Interleaved VC0 (W) and VC1 (S) packets.
    step(1'b1, mk(1, 0, 0, 1), 1'b1);
    step(1'b1, mk(1, 1, 1, 3), 1'b1);
    step(1'b1, mk(0, 0, 2, 2), 1'b1);
    step(1'b1, mk(0, 1, 0, 0), 1'b1);
    step(1'b1, mk(2, 0, 3, 3), 1'b1);
    step(1'b1, mk(2, 1, 0, 0), 1'b1);
    drain();
    chk("t2_err_clean", 80'(err_o), 80'(0));

    // Single flit to Local, then an orphan body on the same VC.
    step(1'b1, mk(3, 2, 1, 1), 1'b1);
    step(1'b1, mk(0, 2, 0, 0), 1'b1);
    drain();
    chk("t3_err_orphan", 80'(err_o), 80'(2'b01));
    do_reset();

    // Double head on VC3; later bodies follow the new route.
    step(1'b1, mk(1, 3, 1, 0), 1'b1);
    step(1'b1, mk(1, 3, 0, 2), 1'b1);
    step(1'b1, mk(0, 3, 1, 1), 1'b1);
    step(1'b1, mk(2, 3, 1, 1), 1'b1);
    drain();
    chk("t4_err_reopen", 80'(err_o), 80'(2'b10));
    do_reset();

    // Backpressure: stall three cycles with a flit waiting, then stream.
    step(1'b1, mk(1, 0, 2, 0), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, mk(0, 0, 0, 0), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, mk(i == 3 ? 2 : 0, 0, 0, 0), 1'b1);
    drain();

    // Reset with a VC1 head in flight; its route must not survive.
    step(1'b1, mk(1, 1, 3, 0), 1'b0);
    step(1'b0, '0, 1'b0);
    do_reset();
    step(1'b1, mk(0, 1, 0, 0), 1'b1);
    drain();
    chk("t6_err_after_rst", 80'(err_o), 80'(2'b01));
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, mk(1, i, 2 + (i % 2), i), 1'b1);
    drain();
`ifdef ROUTE_STATS_EN
    chk("t6_stats_e", 80'(stats_o[63:48]), 80'(3));
`else
    chk("t6_stats_off", stats_o, 80'(0));
`endif
    do_reset();

    // Randomized traffic on all VCs with random handshakes.
    for (int i = 0; i < 600; i++) begin
      int t;
      t = $urandom_range(0, 9);
      step(1'($urandom_range(0, 3) != 0),
           mk(t < 3 ? 1 : (t < 7 ? 0 : (t < 9 ? 2 : 3)), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0));
      if (i == 300) do_reset();
    end
    drain();
    chk("final_empty", 80'(route_valid_o), 80'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
